// File: rtl/hilo_muldiv.sv
// HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO writes (optional macro: HILO_BYPASS_EN).
// Latency: MUL_CYCLES+1 stall cycles for multiply, 33 for divide, 1 for divide-by-zero; MTHI/MTLO visible next cycle.
// Backpressure: stall_o holds IF..EX while an operation is accepted or in flight; flush aborts without touching HI/LO.
`timescale 1ns/1ps
module hilo_muldiv #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] opa, opb;
  logic        op_uns;
  logic [31:0] rem, quo;

  // Operand signs only matter for the signed forms.
  logic        a_neg, b_neg;
  logic [31:0] mag_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_n, quo_n, q_fix, r_fix;
  logic [31:0] src_a_mag;

  assign a_neg = ~op_uns & opa[31];
  assign b_neg = ~op_uns & opb[31];
  assign mag_b = b_neg ? (~opb + 32'd1) : opb;

  // Sign/zero extension to 64 bits lets one unsigned multiply serve both forms.
  assign ext_a = {{32{a_neg}}, opa};
  assign ext_b = {{32{b_neg}}, opb};
  assign prod  = ext_a * ext_b;

  // One restoring-divide step: the partial remainder never exceeds 32 bits once reduced.
  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, mag_b};
  assign rem_n   = ge ? (shifted[31:0] - mag_b) : shifted[31:0];
  assign quo_n   = {quo[30:0], ge};
  assign q_fix   = (a_neg ^ b_neg) ? (~quo_n + 32'd1) : quo_n;
  assign r_fix   = a_neg ? (~rem_n + 32'd1) : rem_n;

  assign src_a_mag = (~op_code[0] & src_a[31]) ? (~src_a + 32'd1) : src_a;

  // Stall while accepting a new operation or while one is in flight.
  always_comb begin
    stall_o = 1'b0;
    if ((state == S_IDLE) && op_valid && !flush) stall_o = 1'b1;
    if ((state == S_MUL) || (state == S_DIV))    stall_o = 1'b1;
  end

`ifdef HILO_BYPASS_EN
  logic byp;
  assign byp  = (state == S_IDLE) && !op_valid && !flush;
  assign hi_o = (byp && hi_we) ? wdata : hi;
  assign lo_o = (byp && lo_we) ? wdata : lo;
`else
  assign hi_o = hi;
  assign lo_o = lo;
`endif

  // Control FSM, operand latches, divide datapath and HI/LO updates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      op_uns <= 1'b0;
      rem    <= 32'd0;
      quo    <= 32'd0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            opa    <= src_a;
            opb    <= src_b;
            op_uns <= op_code[0];
            cnt    <= 6'd0;
            rem    <= 32'd0;
            quo    <= src_a_mag;
            if (!op_code[1]) begin
              state <= S_MUL;
            end else if (src_b != 32'd0) begin
              state <= S_DIV;
            end else begin
              hi    <= src_a;
              lo    <= 32'hFFFF_FFFF;
              state <= S_DONE;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_MUL: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MUL_CYCLES - 1)) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= S_DONE;
          end
        end
        S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi    <= r_fix;
            lo    <= q_fix;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
